// File: rtl/div_sqrt_pkg.sv
// Shared FSM state type and request-entry sizing for the divide/sqrt issue queue.
package div_sqrt_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StHold = 2'd2
  } ds_state_e;

  localparam int unsigned RoundingModeWidth = 3;
  localparam int unsigned ExcFlagsWidth     = 5;

  // Entry layout: {sqrtOp, a, b, roundingMode, tag}.
  function automatic int unsigned req_entry_width(input int unsigned exp_width,
                                                  input int unsigned sig_width,
                                                  input int unsigned tag_width);
    return 1 + 2 * (exp_width + sig_width + 1) + RoundingModeWidth + tag_width;
  endfunction

endpackage

// File: rtl/div_sqrt_issue_queue_if.sv
// Request, unit-issue, unit-result and response signals of the divide/sqrt issue queue.
interface div_sqrt_issue_queue_if #(
  parameter int unsigned expWidth = 8,
  parameter int unsigned sigWidth = 24,
  parameter int unsigned tagWidth = 4
);
  import div_sqrt_pkg::*;

  localparam int unsigned W = expWidth + sigWidth + 1;

  logic                         req_valid;
  logic                         req_ready;
  logic                         req_sqrtOp;
  logic [RoundingModeWidth-1:0] req_roundingMode;
  logic [tagWidth-1:0]          req_tag;
  logic [W-1:0]                 req_a;
  logic [W-1:0]                 req_b;

  logic                         du_inValid;
  logic                         du_inReady;
  logic                         du_sqrtOp;
  logic [W-1:0]                 du_a;
  logic [W-1:0]                 du_b;
  logic [RoundingModeWidth-1:0] du_roundingMode;

  logic                         du_outValid;
  logic                         du_sqrtOpOut;
  logic [W-1:0]                 du_out;
  logic [ExcFlagsWidth-1:0]     du_exceptionFlags;

  logic                         resp_valid;
  logic                         resp_ready;
  logic [W-1:0]                 resp_out;
  logic [ExcFlagsWidth-1:0]     resp_exceptionFlags;
  logic                         resp_sqrtOp;
  logic [tagWidth-1:0]          resp_tag;

  // Environment side: issues requests, models the unit, consumes responses.
  modport master (
    output req_valid, req_sqrtOp, req_roundingMode, req_tag, req_a, req_b,
    input  req_ready,
    input  du_inValid, du_sqrtOp, du_a, du_b, du_roundingMode,
    output du_inReady,
    output du_outValid, du_sqrtOpOut, du_out, du_exceptionFlags,
    input  resp_valid, resp_out, resp_exceptionFlags, resp_sqrtOp, resp_tag,
    output resp_ready
  );

  // Queue side.
  modport slave (
    input  req_valid, req_sqrtOp, req_roundingMode, req_tag, req_a, req_b,
    output req_ready,
    output du_inValid, du_sqrtOp, du_a, du_b, du_roundingMode,
    input  du_inReady,
    input  du_outValid, du_sqrtOpOut, du_out, du_exceptionFlags,
    output resp_valid, resp_out, resp_exceptionFlags, resp_sqrtOp, resp_tag,
    input  resp_ready
  );

endinterface

// File: rtl/div_sqrt_req_fifo.sv
// Power-of-two request FIFO with synchronous reset; head is presented combinationally.
module div_sqrt_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Guard against misuse so the count can never over- or underflow.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/div_sqrt_issue_queue.sv
// Buffers divide/sqrt requests, issues them one at a time to the unit and holds each
// result with its tag until the consumer takes it.
module div_sqrt_issue_queue
  import div_sqrt_pkg::*;
#(
  parameter int unsigned expWidth = 8,
  parameter int unsigned sigWidth = 24,
  parameter int unsigned tagWidth = 4,
  parameter int unsigned depth    = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  div_sqrt_issue_queue_if.slave  bus,
  output logic                   busy,
  output logic                   err_spurious
);

  localparam int unsigned W      = expWidth + sigWidth + 1;
  localparam int unsigned EntryW = req_entry_width(expWidth, sigWidth, tagWidth);
  localparam int unsigned CntW   = $clog2(depth) + 1;

  typedef struct packed {
    logic                         sqrt_op;
    logic [W-1:0]                 a;
    logic [W-1:0]                 b;
    logic [RoundingModeWidth-1:0] rm;
    logic [tagWidth-1:0]          tag;
  } req_entry_t;

  req_entry_t        push_entry;
  req_entry_t        head_entry;
  logic [EntryW-1:0] push_bits;
  logic [EntryW-1:0] head_bits;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CntW-1:0]   fifo_count;

  ds_state_e                state_q, state_d;
  logic                     du_valid;
  logic                     capture;
  logic [tagWidth-1:0]      inflight_tag_q;
  logic [W-1:0]             res_out_q;
  logic [ExcFlagsWidth-1:0] res_flags_q;
  logic                     res_sqrt_q;
  logic [tagWidth-1:0]      res_tag_q;
  logic                     err_q, err_d;

  assign push_entry = '{
    sqrt_op: bus.req_sqrtOp,
    a:       bus.req_a,
    b:       bus.req_b,
    rm:      bus.req_roundingMode,
    tag:     bus.req_tag
  };
  assign push_bits  = push_entry;
  assign head_entry = head_bits;

  // req_ready depends only on the registered count, never on this cycle's pop.
  assign bus.req_ready = !fifo_full;
  assign fifo_push     = bus.req_valid && !fifo_full;

  div_sqrt_req_fifo #(
    .Width (EntryW),
    .Depth (depth)
  ) u_req_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .wdata_i (push_bits),
    .pop_i   (fifo_pop),
    .rdata_o (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    du_valid = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      StIdle: begin
        du_valid = (fifo_count != '0);
        if (du_valid && bus.du_inReady) begin
          fifo_pop = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (bus.du_outValid) begin
          capture = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A result pulse is only expected while an operation is in flight.
  assign err_d = err_q || (bus.du_outValid && (state_q != StBusy));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      inflight_tag_q <= '0;
      res_out_q      <= '0;
      res_flags_q    <= '0;
      res_sqrt_q     <= 1'b0;
      res_tag_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (fifo_pop) begin
        inflight_tag_q <= head_entry.tag;
      end
      if (capture) begin
        res_out_q   <= bus.du_out;
        res_flags_q <= bus.du_exceptionFlags;
        res_sqrt_q  <= bus.du_sqrtOpOut;
        res_tag_q   <= inflight_tag_q;
      end
    end
  end

  assign bus.du_inValid      = du_valid;
  assign bus.du_sqrtOp       = head_entry.sqrt_op;
  assign bus.du_a            = head_entry.a;
  assign bus.du_b            = head_entry.b;
  assign bus.du_roundingMode = head_entry.rm;

  assign bus.resp_valid          = (state_q == StHold);
  assign bus.resp_out            = res_out_q;
  assign bus.resp_exceptionFlags = res_flags_q;
  assign bus.resp_sqrtOp         = res_sqrt_q;
  assign bus.resp_tag            = res_tag_q;

  assign busy         = !fifo_empty || (state_q != StIdle);
  assign err_spurious = err_q;

endmodule

// File: tb/tb_div_sqrt_issue_queue.sv
// Scoreboard bench: queue-level reference model checked every cycle on the falling edge.
module tb_div_sqrt_issue_queue;

  localparam int unsigned EXP   = 8;
  localparam int unsigned SIG   = 24;
  localparam int unsigned TW    = 4;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned W     = EXP + SIG + 1;

  typedef struct {
    logic          sqrt_op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    rm;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    logic [W-1:0]  out;
    logic [4:0]    flags;
    logic          sqrt_op;
    logic [TW-1:0] tag;
  } resp_t;

  logic clk = 1'b0;
  logic reset;
  logic busy, err_spurious;

  div_sqrt_issue_queue_if #(.expWidth(EXP), .sigWidth(SIG), .tagWidth(TW)) bus ();

  div_sqrt_issue_queue #(
    .expWidth (EXP),
    .sigWidth (SIG),
    .tagWidth (TW),
    .depth    (DEPTH)
  ) dut (
    .clock        (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  // Counters and controls
  int   n_vec = 0;
  int   n_bad = 0;
  logic started = 1'b0;
  int   ur_mode = 1;   // du_inReady: 0 low, 1 high, 2 random
  int   rr_mode = 1;   // resp_ready: 0 low, 1 high, 2 random
  int   dly_lo = 10, dly_hi = 10;
  int   spur_reqs = 0;

  // Reference model state (written only by the monitor)
  req_t          mq[$];   // accepted, not yet issued
  resp_t         rq[$];   // results the queue must present, in order
  logic          m_infl = 1'b0;
  logic [TW-1:0] m_tag  = '0;
  logic          m_spur = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic exp_iv, iss, acc;
    if (started) begin
      exp_iv = !m_infl && (rq.size() == 0) && (mq.size() != 0);
      chk("req_ready", 64'(bus.req_ready), 64'(mq.size() < DEPTH));
      chk("du_inValid", 64'(bus.du_inValid), 64'(exp_iv));
      chk("resp_valid", 64'(bus.resp_valid), 64'(rq.size() != 0));
      chk("busy", 64'(busy), 64'((mq.size() != 0) || m_infl || (rq.size() != 0)));
      chk("err_spurious", 64'(err_spurious), 64'(m_spur));
      if (exp_iv) begin
        chk("du_a", 64'(bus.du_a), 64'(mq[0].a));
        chk("du_b", 64'(bus.du_b), 64'(mq[0].b));
        chk("du_sqrtOp", 64'(bus.du_sqrtOp), 64'(mq[0].sqrt_op));
        chk("du_roundingMode", 64'(bus.du_roundingMode), 64'(mq[0].rm));
      end
      if (rq.size() != 0) begin
        chk("resp_out", 64'(bus.resp_out), 64'(rq[0].out));
        chk("resp_exceptionFlags", 64'(bus.resp_exceptionFlags), 64'(rq[0].flags));
        chk("resp_sqrtOp", 64'(bus.resp_sqrtOp), 64'(rq[0].sqrt_op));
        chk("resp_tag", 64'(bus.resp_tag), 64'(rq[0].tag));
      end
      if (reset) begin
        mq.delete();
        rq.delete();
        m_infl = 1'b0;
        m_spur = 1'b0;
      end else begin
        iss = exp_iv && bus.du_inReady;
        acc = bus.req_valid && (mq.size() < DEPTH);
        if (bus.du_outValid) begin
          if (m_infl) begin
            rq.push_back('{out: bus.du_out, flags: bus.du_exceptionFlags,
                           sqrt_op: bus.du_sqrtOpOut, tag: m_tag});
            m_infl = 1'b0;
          end else begin
            m_spur = 1'b1;
          end
        end else if ((rq.size() != 0) && bus.resp_ready) begin
          void'(rq.pop_front());
        end
        if (iss) begin
          m_infl = 1'b1;
          m_tag  = mq[0].tag;
          void'(mq.pop_front());
        end
        if (acc) begin
          mq.push_back('{sqrt_op: bus.req_sqrtOp, a: bus.req_a, b: bus.req_b,
                         rm: bus.req_roundingMode, tag: bus.req_tag});
        end
      end
    end
  end

  // Divide/sqrt unit model: answers each issue after a delay, or fires a requested stray pulse.
  initial begin
    logic        iss, rst_s, pend;
    int          cnt, spur_done;
    logic [63:0] r;
    pend = 1'b0;
    cnt = 0;
    spur_done = 0;
    bus.du_inReady        = 1'b0;
    bus.du_outValid       = 1'b0;
    bus.du_sqrtOpOut      = 1'b0;
    bus.du_out            = '0;
    bus.du_exceptionFlags = '0;
    forever begin
      @(negedge clk);
      iss   = bus.du_inValid && bus.du_inReady && !reset;
      rst_s = reset;
      @(posedge clk);
      #1;
      bus.du_outValid = 1'b0;
      if (rst_s) begin
        pend = 1'b0;
      end else if (pend) begin
        if (cnt == 0) begin
          r = {$urandom, $urandom};
          bus.du_outValid       = 1'b1;
          bus.du_out            = r[W-1:0];
          bus.du_exceptionFlags = r[63:59];
          bus.du_sqrtOpOut      = r[40];
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end else if (spur_done != spur_reqs) begin
        spur_done++;
        r = {$urandom, $urandom};
        bus.du_outValid = 1'b1;
        bus.du_out      = r[W-1:0];
      end
      if (iss) begin
        pend = 1'b1;
        cnt  = $urandom_range(dly_hi, dly_lo);
      end
      bus.du_inReady = (ur_mode == 2) ? (($urandom & 1) != 0) : (ur_mode != 0);
    end
  end

  initial begin
    bus.resp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.resp_ready = (rr_mode == 2) ? (($urandom & 1) != 0) : (rr_mode != 0);
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] rm, input logic [TW-1:0] t);
    logic acc;
    int   n;
    bus.req_valid        = 1'b1;
    bus.req_sqrtOp       = s;
    bus.req_a            = a;
    bus.req_b            = b;
    bus.req_roundingMode = rm;
    bus.req_tag          = t;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.req_ready;
      n++;
    end while (!acc && n < 1000);
    if (!acc) begin
      $display("FAIL req_accept: req_ready still 0 after %0d cycles, expected 1 (tag %0d)", n, t);
      $fatal(1);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [TW-1:0] t);
    logic [63:0] ra, rb;
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    send((($urandom & 1) != 0), ra[W-1:0], rb[W-1:0], 3'($urandom_range(7, 0)), t);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (((mq.size() != 0) || m_infl || (rq.size() != 0)) && n < 3000) begin
      cycles(1);
      n++;
    end
    if (n >= 3000) begin
      $display("FAIL drain: model still busy after %0d cycles, expected idle", n);
      $fatal(1);
    end
    cycles(2);
  endtask

  task automatic wait_hold();
    int n = 0;
    while ((rq.size() == 0) && n < 500) begin
      cycles(1);
      n++;
    end
    if (n >= 500) begin
      $display("FAIL hold_wait: no result after %0d cycles, expected one", n);
      $fatal(1);
    end
  endtask

  initial begin
    reset                = 1'b1;
    bus.req_valid        = 1'b0;
    bus.req_sqrtOp       = 1'b0;
    bus.req_a            = '0;
    bus.req_b            = '0;
    bus.req_roundingMode = '0;
    bus.req_tag          = '0;
    cycles(2);
    started = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(1);

    // Single divide of 1.0 / 1.0
    send(1'b0, 33'h080000000, 33'h080000000, 3'd0, 4'd3);
    wait_idle();

    // Queue fill with the unit stalled
    ur_mode = 0;
    cycles(2);
    send_rand(4'd1);
    send_rand(4'd2);
    fork
      send_rand(4'd3);
      begin
        cycles(5);
        ur_mode = 1;
      end
    join
    wait_idle();

    // Response backpressure for 20 cycles, with a request waiting behind it
    dly_lo = 3;
    dly_hi = 3;
    rr_mode = 0;
    send_rand(4'd5);
    wait_hold();
    send_rand(4'd6);
    cycles(20);
    rr_mode = 1;
    wait_idle();

    // Stray result pulse while idle; the flag must survive normal traffic
    spur_reqs++;
    cycles(6);
    send_rand(4'd10);
    wait_idle();

    // Reset while busy with one entry queued
    dly_lo = 30;
    dly_hi = 30;
    send_rand(4'd7);
    send_rand(4'd8);
    cycles(3);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    cycles(2);
    dly_lo = 4;
    dly_hi = 4;
    send_rand(4'd9);
    wait_idle();

    // Randomised traffic
    ur_mode = 2;
    rr_mode = 2;
    dly_lo = 0;
    dly_hi = 6;
    for (int i = 0; i < 150; i++) begin
      send_rand(TW'($urandom_range(15, 0)));
      cycles($urandom_range(3, 0));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/div_sqrt_issue_queue.md
DIV_SQRT_ISSUE_QUEUE -- requirements
Module: div_sqrt_issue_queue

Interface
REQ-001 Parameter expWidth, default 8: exponent width of the recoded operands and result.
REQ-002 Parameter sigWidth, default 24: significand width; the recoded word width is W = expWidth+sigWidth+1.
REQ-003 Parameter tagWidth, default 4: width of the opaque request tag returned with each result.
REQ-004 Parameter depth, default 2: number of request FIFO entries; legal values are powers of 2 that are 2 or greater.
REQ-005 Clocking and reset SHALL be one clock and a synchronous, active-high reset; there is no other clock or reset.
REQ-006 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port req_valid/req_ready, input/output, 1/1: upstream request handshake; a transfer occurs when both are 1.
REQ-009 Port req_sqrtOp, req_roundingMode, req_tag, inputs, widths 1/3/tagWidth: operation, rounding mode and tag.
REQ-010 Port req_a, req_b, inputs, W each: recoded operands.
REQ-011 Port du_inValid, du_sqrtOp, du_a, du_b, du_roundingMode, outputs, widths 1/1/W/W/3: issue port to the divide/sqrt unit.
REQ-012 Port du_inReady, input, 1: the unit can accept an operation.
REQ-013 Port du_outValid, du_sqrtOpOut, du_out, du_exceptionFlags, inputs, widths 1/1/W/5: unit result; du_outValid is a one-cycle pulse with no backpressure.
REQ-014 Port resp_valid, output, 1 and resp_ready, input, 1: downstream response handshake.
REQ-015 Port resp_out, resp_exceptionFlags, resp_sqrtOp, resp_tag, outputs, widths W/5/1/tagWidth: the held result.
REQ-016 Port busy, output, 1: 1 when the FIFO is non-empty or the FSM is not IDLE.
REQ-017 Port err_spurious, output, 1: sticky flag for an unexpected du_outValid.

Function
REQ-018 Request FIFO: depth entries holding {sqrtOp, a, b, roundingMode, tag}.
- Read and write pointers wrap modulo depth; the count has log2(depth)+1 bits.
- req_ready SHALL be 1 exactly when count < depth; req_ready has no combinational dependence on the pop.
REQ-019 Push and pop in the same cycle SHALL leave the count unchanged and preserve order.
- Push while full is impossible, because req_ready is 0.
REQ-020 The FSM SHALL have three states:
- IDLE: no operation outstanding and the result buffer is empty.
- BUSY: one operation is in flight in the unit.
- HOLD: the result buffer is full.
REQ-021 In IDLE, du_inValid SHALL equal (count != 0); the du_* operand outputs SHALL be driven combinationally from the FIFO head.
REQ-022 In IDLE, when du_inValid and du_inReady are both 1:
- pop the FIFO head;
- latch the head tag into inflight_tag;
- go to BUSY.
REQ-023 In BUSY and HOLD, du_inValid SHALL be 0.
REQ-024 In BUSY, a du_outValid pulse SHALL:
- capture du_out, du_exceptionFlags, du_sqrtOpOut and inflight_tag into the result buffer;
- go to HOLD.
REQ-025 In HOLD, resp_valid SHALL be 1 and the resp_* outputs SHALL stay stable until resp_ready is 1; that cycle returns the FSM to IDLE.
REQ-026 A du_outValid pulse in IDLE or HOLD SHALL be ignored for data and SHALL set err_spurious, which stays 1 until reset.
REQ-027 Latency: a request accepted at edge N into an empty FIFO with the FSM in IDLE SHALL show du_inValid=1 in cycle N+1.
- A du_outValid at edge M SHALL give resp_valid=1 in cycle M+1.
REQ-028 At most one operation is in flight; results therefore return in issue order with the correct tag.

Reset
REQ-029 On reset the block SHALL:
- set pointers and count to 0;
- set the FSM to IDLE;
- set req_ready=1, du_inValid=0, resp_valid=0, busy=0, err_spurious=0;
- set resp_* data and inflight_tag to 0.
REQ-030 Reset asserted mid-operation SHALL discard FIFO contents and any in-flight or held result. The integrator resets the unit on the same reset; a stale du_outValid after reset is handled per REQ-026.

Structure
REQ-031 Package div_sqrt_pkg SHALL hold:
- the FSM state enum (IDLE, BUSY, HOLD);
- the request-entry width function of expWidth, sigWidth and tagWidth.
REQ-032 The FIFO SHALL be one sub-module, div_sqrt_req_fifo: parameterized width and depth, synchronous reset, push/pop/full/empty/count ports.

Verification
REQ-033 Single divide test:
- Stimulus: req a=0x080000000 (recoded 1.0), b=0x080000000, tag=3; du_inReady=1; model du_outValid 10 cycles after issue.
- Required: du_inValid in cycle 1; resp_valid one cycle after the pulse with resp_tag=3; busy returns to 0 after drain.
REQ-034 Queue fill test:
- Stimulus: push 3 requests back-to-back (tags 1, 2, 3) with du_inReady=0.
- Required: req_ready drops after the 2nd request; the 3rd is accepted only after the first issue; responses return tags 1, 2, 3 in order.
REQ-035 Backpressure test:
- Stimulus: resp_ready=0 for 20 cycles in HOLD.
- Required: resp_* stable; du_inValid=0; no new issue until the release cycle.
REQ-036 Spurious-pulse test:
- Stimulus: du_outValid pulse while IDLE.
- Required: err_spurious=1 next cycle; no resp_valid; the flag persists until reset.
REQ-037 Reset-in-BUSY test:
- Stimulus: assert reset for 1 cycle while BUSY with 1 queued entry.
- Required: all outputs at reset values next cycle; count=0; a subsequent request issues normally.
